// File: rtl/apb_pkg.sv
// Shared definitions for the arbitrated APB master: FSM state encoding,
// default bus widths and the default ACCESS-phase wait limit.
package apb_pkg;

   localparam int ADDR_W_DEF  = 4;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 15;

   // Wait counter width; wide enough for the largest allowed limit (255).
   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_RDCAP  = 3'd3,
      ST_DONE   = 3'd4
   } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_protocol_chk.sv
// APB protocol checker: address/control/write data held from SETUP through
// the end of ACCESS, Penable only together with Psel, SETUP followed by ACCESS.
module apb_protocol_chk #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input logic              PCLK,
   input logic              Presetn,
   input logic              Psel,
   input logic              Penable,
   input logic [ADDR_W-1:0] Paddr,
   input logic              Pwrite,
   input logic [DATA_W-1:0] Pwdata
);

   a_enable_needs_sel : assert property (@(posedge PCLK) disable iff (!Presetn)
      Penable |-> Psel);

   a_ctrl_stable : assert property (@(posedge PCLK) disable iff (!Presetn)
      (Psel && $past(Psel)) |-> ($stable(Paddr) && $stable(Pwrite) && $stable(Pwdata)));

   a_setup_then_access : assert property (@(posedge PCLK) disable iff (!Presetn)
      (Psel && !Penable) |=> (Psel && Penable));

endmodule : apb_protocol_chk

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win
// last time is chosen; a lone requester always wins.
module apb_rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_gnt,
   output logic grant,
   output logic grant_id
);

   // Pick a winner from the two valids and the last-grant pointer.
   always_comb begin
      grant    = valid0 | valid1;
      grant_id = 1'b0;
      if (valid0 && valid1) begin
         grant_id = ~last_gnt;
      end else if (valid1) begin
         grant_id = 1'b1;
      end else begin
         grant_id = 1'b0;
      end
   end

endmodule : apb_rr_arb2

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters. A round-robin arbiter picks a
// requester in IDLE; the latched transfer then runs SETUP -> ACCESS
// (-> RDCAP for reads) -> DONE. ACCESS is bounded by a wait counter.
module apb_arb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              PCLK,
   input  logic              Presetn,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic [ADDR_W-1:0] Paddr,
   output logic              Pwrite,
   output logic [DATA_W-1:0] Pwdata,
   output logic              Psel,
   output logic              Penable,
   input  logic              Pready,
   input  logic [DATA_W-1:0] Prdata
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   apb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gid_q, gid_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              err0_q, err0_d;
   logic              err1_q, err1_d;

   logic              arb_grant_s;
   logic              arb_id_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic              fin_s;
   logic              fin_err_s;
   logic [DATA_W-1:0] fin_rdata_s;

   apb_rr_arb2 u_arb (
      .valid0   (req0_valid),
      .valid1   (req1_valid),
      .last_gnt (last_q),
      .grant    (arb_grant_s),
      .grant_id (arb_id_s)
   );

   // Accept pulses are issued in the same IDLE cycle the grant is decided,
   // so a held request is taken on the first edge; forced low during reset.
   assign req0_ready = Presetn & (state_q == ST_IDLE) & arb_grant_s & ~arb_id_s;
   assign req1_ready = Presetn & (state_q == ST_IDLE) & arb_grant_s &  arb_id_s;

   // Next-state, transfer latching and next values of all registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gid_d       = gid_q;
      last_d      = last_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      rdata0_d    = {DATA_W{1'b0}};
      rdata1_d    = {DATA_W{1'b0}};
      err0_d      = 1'b0;
      err1_d      = 1'b0;
      fin_s       = 1'b0;
      fin_err_s   = 1'b0;
      fin_rdata_s = {DATA_W{1'b0}};
      cnt_inc_s   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

      case (state_q)
         ST_IDLE: begin
            if (arb_grant_s) begin
               gid_d    = arb_id_s;
               last_d   = arb_id_s;
               paddr_d  = arb_id_s ? req1_addr  : req0_addr;
               pwrite_d = arb_id_s ? req1_write : req0_write;
               pwdata_d = arb_id_s ? req1_wdata : req0_wdata;
               psel_d   = 1'b1;
               state_d  = ST_SETUP;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_SETUP: begin
            cnt_d     = {CNT_W{1'b0}};
            psel_d    = 1'b1;
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (Pready) begin
               if (pwrite_q) begin
                  fin_s   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RDCAP;
               end
            end else if (cnt_inc_s == TIMEOUT_C) begin
               cnt_d     = cnt_inc_s;
               fin_s     = 1'b1;
               fin_err_s = 1'b1;
               state_d   = ST_DONE;
            end else begin
               cnt_d     = cnt_inc_s;
               psel_d    = 1'b1;
               penable_d = 1'b1;
               state_d   = ST_ACCESS;
            end
         end
         ST_RDCAP: begin
            fin_s       = 1'b1;
            fin_rdata_s = Prdata;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Completion results are routed only to the requester that owns the transfer.
      if (fin_s) begin
         if (gid_q) begin
            done1_d  = 1'b1;
            rdata1_d = fin_rdata_s;
            err1_d   = fin_err_s;
         end else begin
            done0_d  = 1'b1;
            rdata0_d = fin_rdata_s;
            err0_d   = fin_err_s;
         end
      end else begin
         done0_d = 1'b0;
         done1_d = 1'b0;
      end
   end

   // State and output registers; reset abandons any transfer in flight.
   always_ff @(posedge PCLK or negedge Presetn) begin
      if (!Presetn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         gid_q     <= 1'b0;
         last_q    <= 1'b1;
         paddr_q   <= {ADDR_W{1'b0}};
         pwrite_q  <= 1'b0;
         pwdata_q  <= {DATA_W{1'b0}};
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         rdata0_q  <= {DATA_W{1'b0}};
         rdata1_q  <= {DATA_W{1'b0}};
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gid_q     <= gid_d;
         last_q    <= last_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
      end
   end

   assign Paddr      = paddr_q;
   assign Pwrite     = pwrite_q;
   assign Pwdata     = pwdata_q;
   assign Psel       = psel_q;
   assign Penable    = penable_q;
   assign req0_done  = done0_q;
   assign req1_done  = done1_q;
   assign req0_rdata = rdata0_q;
   assign req1_rdata = rdata1_q;
   assign req0_err   = err0_q;
   assign req1_err   = err1_q;

endmodule : apb_arb_master

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter ADDR_W, 4, APB address width.
REQ-002 Parameter DATA_W, 32, APB data width.
REQ-003 Parameter TIMEOUT, 15, maximum ACCESS-phase cycles to wait for Pready (range 1..255).
REQ-004 PCLK  in  1  APB clock; all state updates on the rising edge.
REQ-005 Presetn  in  1  reset, asynchronous, active-low.
REQ-006 reqN_valid  in  1  requester N (N=0,1) has a transfer pending; held high until reqN_ready.
REQ-007 reqN_write  in  1  1 = write, 0 = read; stable while reqN_valid is high.
REQ-008 reqN_addr  in  ADDR_W  target register index.
REQ-009 reqN_wdata  in  DATA_W  write data.
REQ-010 reqN_ready  out  1  single-cycle pulse; request accepted (granted).
REQ-011 reqN_done  out  1  single-cycle pulse; transfer complete.
REQ-012 reqN_rdata  out  DATA_W  read data; valid while reqN_done is high.
REQ-013 reqN_err  out  1  timeout flag; valid while reqN_done is high.
REQ-014 Paddr, Pwrite, Pwdata  out  ADDR_W/1/DATA_W  APB address, direction and write data.
REQ-015 Psel, Penable  out  1  APB select and enable.
REQ-016 Pready  in  1  slave ready.
REQ-017 Prdata  in  DATA_W  slave read data; registered by the slave, valid one cycle after the completing ACCESS cycle.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS, RDCAP, DONE.
REQ-019 IDLE: if any reqN_valid is high, grant one requester, pulse its reqN_ready, latch addr/write/wdata/grant id, go to SETUP; otherwise stay in IDLE.
REQ-020 Arbitration is round-robin: on simultaneous requests the requester not granted last wins; after reset the last-grant pointer is 1, so req0 wins the first tie.
REQ-021 SETUP: Psel=1, Penable=0, latched Paddr/Pwrite/Pwdata driven; always advances to ACCESS after one cycle.
REQ-022 ACCESS: Psel=1, Penable=1; Paddr/Pwrite/Pwdata are held stable for the whole phase.
REQ-023 ACCESS with Pready=1: a write goes to DONE and a read goes to RDCAP.
REQ-024 RDCAP: Psel=0, Penable=0; capture Prdata into the read-data register and go to DONE.
REQ-025 DONE: pulse done for the granted requester for one cycle, then return to IDLE; the rdata and err outputs of the non-granted requester stay 0.
REQ-026 Write done: rdata=0, err=0. Read done: rdata=captured value, err=0.
REQ-027 The wait counter clears on entry to ACCESS and increments on each ACCESS cycle with Pready=0.
REQ-028 If the counter reaches TIMEOUT, drop Psel/Penable, go to DONE with err=1 and rdata=0.
REQ-029 The minimum transfer is 4 cycles for a write (accept through done) and 5 cycles for a read; there is no back-to-back overlap.
REQ-030 A request arriving outside IDLE is not accepted until the FSM returns to IDLE.
REQ-031 Deasserting reqN_valid before reqN_ready is a protocol violation; behaviour is unspecified.
REQ-032 Psel=0 and Penable=0 in IDLE, RDCAP and DONE; Penable is never 1 while Psel is 0.

Reset
REQ-033 Presetn low forces IDLE asynchronously and clears the counter, the latched transfer and the read-data register, and sets the last-grant pointer to 1.
REQ-034 Reset values of all outputs are 0.
REQ-035 Reset asserted mid-transfer abandons the transfer silently: no done pulse, Psel and Penable drop immediately.
REQ-036 After reset release, the first transfer can be accepted on the first rising edge.

Structure
REQ-037 A shared package apb_pkg holds the FSM state enum, ADDR_W/DATA_W defaults and the TIMEOUT default.
REQ-038 The round-robin grant logic is one sub-module, apb_rr_arb2 (inputs: two valids plus the last-grant pointer; outputs: grant and grant id).
REQ-039 The implementation is a single registered FSM with no combinational path from reqN_* to APB outputs.

Verification
REQ-040 Single write: req0 writes addr 3, data 0xDEADBEEF -> ready at cycle 0, SETUP, ACCESS, done at cycle 3 with err=0; a subsequent read of addr 3 returns 0xDEADBEEF.
REQ-041 Single read: req1 reads addr 0 after reset -> done at cycle 4, rdata=0x00000000, Psel high for exactly 2 cycles.
REQ-042 Contention: req0 and req1 both valid after reset and held -> grants in order 0,1,0,1; no requester is granted twice in a row while the other is waiting.
REQ-043 Timeout: Pready forced 0, TIMEOUT=15 -> done with err=1 after 15 ACCESS cycles; Psel drops in the same cycle.
REQ-044 Reset mid-ACCESS: Presetn low during ACCESS -> Psel=Penable=0 immediately; no done pulse; the next request is served normally.
REQ-045 Protocol check: an assertion checks that Paddr, Pwrite and Pwdata are stable from SETUP through the end of ACCESS, and that Penable implies Psel.
